// File: rtl/u_pkg.sv
// Shared definitions for the unary/thermometer admission pipeline.
// The result struct itself lives in each module because its len field depends on W.
package u_pkg;

  // Width of the decoded run-length field for a W-bit input vector.
  function automatic int unsigned u_len_w(input int unsigned w);
    return $clog2(w);
  endfunction

  typedef enum logic [1:0] {
    U_CLS_INVALID = 2'd0,
    U_CLS_STD     = 2'd1,
    U_CLS_COMP    = 2'd2
  } u_cls_e;

endpackage

// File: rtl/u_dec.sv
// Combinational unary decoder: classifies x as standard, complement or invalid
// and encodes the run length from a one-hot pivot.
module u_dec
  import u_pkg::*;
#(
  parameter int unsigned W                     = 16,
  parameter bit          P_ADMIT_COMPLIMENT_EN = 1'b1,
  localparam int unsigned LW                   = u_len_w(W)
) (
  input  logic [W-1:0]  x,
  output logic [LW+1:0] res
);

  typedef struct packed {
    logic          is_unary;
    logic          is_compliment;
    logic [LW-1:0] len;
  } u_res_t;

  function automatic logic [W-1:0] low_mask(input int unsigned k);
    logic [W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (i < k) m[i] = 1'b1;
    end
    return m;
  endfunction

  logic [W-1:0] std_hit;
  logic [W-1:0] comp_hit;
  logic [W-1:0] hit;
  logic [W-1:0] m;
  u_cls_e       cls;
  u_res_t       r;

  // Pivot k: bits below k form the run, bits at/above k must all be the fill value.
  always_comb begin
    std_hit  = '0;
    comp_hit = '0;
    m        = '0;
    for (int unsigned k = 0; k < W; k++) begin
      m           = low_mask(k);
      std_hit[k]  = (&(x | ~m)) && !(|(x & ~m));
      comp_hit[k] = P_ADMIT_COMPLIMENT_EN && (&(~x | ~m)) && !(|(~x & ~m));
    end
  end

  assign hit = std_hit | comp_hit;

  always_comb begin
    r     = '0;
    cls   = U_CLS_INVALID;
    if (|std_hit)       cls = U_CLS_STD;
    else if (|comp_hit) cls = U_CLS_COMP;
    for (int unsigned k = 0; k < W; k++) begin
      if (hit[k]) r.len = r.len | LW'(k);
    end
    r.is_unary      = (cls != U_CLS_INVALID);
    r.is_compliment = (cls == U_CLS_COMP);
  end

  assign res = r;

endmodule

// File: rtl/u_pipe.sv
// Two-stage valid/ready pipeline: S1 holds the raw vector, S2 the decoded result.
// A saturating counter tallies rejected results as they are consumed.
module u_pipe
  import u_pkg::*;
#(
  parameter int unsigned W                     = 16,
  parameter bit          P_ADMIT_COMPLIMENT_EN = 1'b1,
  parameter int unsigned CNT_W                 = 16,
  localparam int unsigned LW                   = u_len_w(W)
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             i_in_vld,
  input  logic [W-1:0]     i_in_x,
  output logic             o_in_rdy,
  output logic             o_out_vld,
  input  logic             i_out_rdy,
  output logic             o_out_is_unary,
  output logic             o_out_is_compliment,
  output logic [LW-1:0]    o_out_len,
  input  logic             i_rej_cnt_clr,
  output logic [CNT_W-1:0] o_rej_cnt
);

  typedef struct packed {
    logic          is_unary;
    logic          is_compliment;
    logic [LW-1:0] len;
  } u_res_t;

  logic             s1_vld;
  logic [W-1:0]     s1_x;
  logic             s2_vld;
  u_res_t           s2_res;
  logic [LW+1:0]    dec_res;
  u_res_t           dec_r;
  logic             in_xfer;
  logic             out_xfer;
  logic             s2_load;
  logic [CNT_W-1:0] rej_cnt;

  assign o_in_rdy = !(s1_vld && s2_vld && !i_out_rdy);
  assign in_xfer  = i_in_vld && o_in_rdy;
  assign out_xfer = s2_vld && i_out_rdy;
  assign s2_load  = s1_vld && (!s2_vld || i_out_rdy);

  u_dec #(
    .W                     (W),
    .P_ADMIT_COMPLIMENT_EN (P_ADMIT_COMPLIMENT_EN)
  ) u_dec_i (
    .x   (s1_x),
    .res (dec_res)
  );

  assign dec_r = u_res_t'(dec_res);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      s1_vld <= 1'b0;
      s1_x   <= '0;
    end else if (in_xfer) begin
      s1_vld <= 1'b1;
      s1_x   <= i_in_x;
    end else if (s2_load) begin
      s1_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      s2_vld <= 1'b0;
      s2_res <= '0;
    end else if (s2_load) begin
      s2_vld <= 1'b1;
      s2_res <= dec_r;
    end else if (out_xfer) begin
      s2_vld <= 1'b0;
    end
  end

  // Clear takes priority; saturation holds the counter at all-ones.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rej_cnt <= '0;
    end else if (i_rej_cnt_clr) begin
      rej_cnt <= '0;
    end else if (out_xfer && !s2_res.is_unary && (rej_cnt != '1)) begin
      rej_cnt <= rej_cnt + CNT_W'(1);
    end
  end

  assign o_out_vld           = s2_vld;
  assign o_out_is_unary      = s2_res.is_unary;
  assign o_out_is_compliment = s2_res.is_compliment;
  assign o_out_len           = s2_res.len;
  assign o_rej_cnt           = rej_cnt;

endmodule

// File: tb/tb_u_pipe.sv
// Directed bench for u_pipe at W=8: dut_a admits the complement form with a wide
// counter, dut_b rejects it with a 2-bit counter; both see the same stream.
module tb_u_pipe;

  logic        clk;
  logic        arst_n;
  logic        in_vld;
  logic [7:0]  in_x;
  logic        out_rdy;
  logic        clr_a;
  logic        clr_b;

  logic        a_in_rdy, a_vld, a_u, a_c;
  logic [2:0]  a_len;
  logic [15:0] a_rej;
  logic        b_in_rdy, b_vld, b_u, b_c;
  logic [2:0]  b_len;
  logic [1:0]  b_rej;

  int n_total = 0;
  int n_bad   = 0;
  logic [7:0] v;

  u_pipe #(.W(8), .P_ADMIT_COMPLIMENT_EN(1'b1), .CNT_W(16)) dut_a (
    .clk                 (clk),
    .arst_n              (arst_n),
    .i_in_vld            (in_vld),
    .i_in_x              (in_x),
    .o_in_rdy            (a_in_rdy),
    .o_out_vld           (a_vld),
    .i_out_rdy           (out_rdy),
    .o_out_is_unary      (a_u),
    .o_out_is_compliment (a_c),
    .o_out_len           (a_len),
    .i_rej_cnt_clr       (clr_a),
    .o_rej_cnt           (a_rej)
  );

  u_pipe #(.W(8), .P_ADMIT_COMPLIMENT_EN(1'b0), .CNT_W(2)) dut_b (
    .clk                 (clk),
    .arst_n              (arst_n),
    .i_in_vld            (in_vld),
    .i_in_x              (in_x),
    .o_in_rdy            (b_in_rdy),
    .o_out_vld           (b_vld),
    .i_out_rdy           (out_rdy),
    .o_out_is_unary      (b_u),
    .o_out_is_compliment (b_c),
    .o_out_len           (b_len),
    .i_rej_cnt_clr       (clr_b),
    .o_rej_cnt           (b_rej)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One isolated vector: accepted at the first edge, visible after the second,
  // consumed at the third (optionally with the counters cleared on that edge).
  task automatic send(input string tag, input logic [7:0] x, input logic do_clr,
                      input logic eu_a, input logic ec_a, input logic [2:0] el_a,
                      input logic eu_b, input logic [2:0] el_b);
    @(negedge clk);
    in_vld = 1'b1;
    in_x   = x;
    @(negedge clk);
    in_vld = 1'b0;
    chk({tag, ".vld_early"}, a_vld, 1'b0);
    @(negedge clk);
    chk({tag, ".a_vld"}, a_vld, 1'b1);
    chk({tag, ".a_u"},   a_u,   eu_a);
    chk({tag, ".a_c"},   a_c,   ec_a);
    chk({tag, ".a_len"}, a_len, el_a);
    chk({tag, ".b_vld"}, b_vld, 1'b1);
    chk({tag, ".b_u"},   b_u,   eu_b);
    chk({tag, ".b_c"},   b_c,   1'b0);
    chk({tag, ".b_len"}, b_len, el_b);
    clr_a = do_clr;
    clr_b = do_clr;
    @(negedge clk);
    clr_a = 1'b0;
    clr_b = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    arst_n  = 1'b1;
    in_vld  = 1'b0;
    in_x    = '0;
    out_rdy = 1'b1;
    clr_a   = 1'b0;
    clr_b   = 1'b0;
    #1 arst_n = 1'b0;
    #1;
    chk("rst.a_vld", a_vld, 1'b0);
    chk("rst.b_vld", b_vld, 1'b0);
    chk("rst.a_u",   a_u,   1'b0);
    chk("rst.a_c",   a_c,   1'b0);
    chk("rst.a_len", a_len, 3'd0);
    chk("rst.a_rej", a_rej, 16'd0);
    chk("rst.b_rej", b_rej, 2'd0);
    @(negedge clk);
    arst_n = 1'b1;
    #1;
    chk("rst.a_in_rdy", a_in_rdy, 1'b1);

    for (int k = 0; k < 8; k++) begin
      v = 8'((1 << k) - 1);
      send("sweep", v, 1'b0, 1'b1, 1'b0, 3'(k), 1'b1, 3'(k));
    end
    chk("sweep.a_rej", a_rej, 16'd0);
    chk("sweep.b_rej", b_rej, 2'd0);

    send("f0", 8'hF0, 1'b0, 1'b1, 1'b1, 3'd4, 1'b0, 3'd0);
    chk("f0.a_rej", a_rej, 16'd0);
    chk("f0.b_rej", b_rej, 2'd1);
    send("ff", 8'hFF, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0);
    send("c0", 8'hC0, 1'b0, 1'b1, 1'b1, 3'd6, 1'b0, 3'd0);
    chk("c0.b_rej", b_rej, 2'd3);
    send("05", 8'h05, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
    send("bf", 8'hBF, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
    chk("inv.a_rej", a_rej, 16'd2);
    chk("sat.b_rej", b_rej, 2'd3);

    send("clr", 8'h05, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
    chk("clr.a_rej", a_rej, 16'd0);
    chk("clr.b_rej", b_rej, 2'd0);

    // Backpressure: V0=03 V1=1F V2=01 V3=7F with the consumer stalled.
    @(negedge clk);
    out_rdy = 1'b0;
    in_vld  = 1'b1;
    in_x    = 8'h03;
    #1 chk("bp.rdy0", a_in_rdy, 1'b1);
    @(negedge clk);
    in_x = 8'h1F;
    chk("bp.rdy1", a_in_rdy, 1'b1);
    @(negedge clk);
    in_x = 8'h01;
    chk("bp.rdy2",  a_in_rdy, 1'b0);
    chk("bp.b_rdy2", b_in_rdy, 1'b0);
    chk("bp.vld2",  a_vld,    1'b1);
    chk("bp.len2",  a_len,    3'd2);
    @(negedge clk);
    chk("bp.rdy3",  a_in_rdy, 1'b0);
    chk("bp.vld3",  a_vld,    1'b1);
    chk("bp.len3",  a_len,    3'd2);
    chk("bp.u3",    a_u,      1'b1);
    out_rdy = 1'b1;
    #1 chk("bp.rdy_rise", a_in_rdy, 1'b1);
    @(negedge clk);
    chk("bp.len_v1", a_len, 3'd5);
    chk("bp.vld_v1", a_vld, 1'b1);
    in_x = 8'h7F;
    @(negedge clk);
    in_vld = 1'b0;
    chk("bp.len_v2", a_len, 3'd1);
    chk("bp.vld_v2", a_vld, 1'b1);
    @(negedge clk);
    chk("bp.len_v3", a_len, 3'd7);
    chk("bp.vld_v3", a_vld, 1'b1);
    @(negedge clk);
    chk("bp.drain", a_vld, 1'b0);
    chk("bp.a_rej", a_rej, 16'd0);

    send("prerst", 8'h05, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
    chk("prerst.a_rej", a_rej, 16'd1);
    chk("prerst.b_rej", b_rej, 2'd1);

    // Fill both stages, then reset mid-cycle.
    @(negedge clk);
    out_rdy = 1'b0;
    in_vld  = 1'b1;
    in_x    = 8'h0F;
    @(negedge clk);
    in_x = 8'h05;
    @(negedge clk);
    in_vld = 1'b0;
    chk("full.vld", a_vld,    1'b1);
    chk("full.rdy", a_in_rdy, 1'b0);
    #2 arst_n = 1'b0;
    #1;
    chk("mid.a_vld", a_vld, 1'b0);
    chk("mid.b_vld", b_vld, 1'b0);
    chk("mid.a_u",   a_u,   1'b0);
    chk("mid.a_len", a_len, 3'd0);
    chk("mid.a_rej", a_rej, 16'd0);
    chk("mid.b_rej", b_rej, 2'd0);
    @(negedge clk);
    arst_n  = 1'b1;
    out_rdy = 1'b1;
    #1 chk("post.rdy", a_in_rdy, 1'b1);
    @(negedge clk);
    chk("post.idle1", a_vld, 1'b0);
    @(negedge clk);
    chk("post.idle2", a_vld, 1'b0);
    send("post", 8'h07, 1'b0, 1'b1, 1'b0, 3'd3, 1'b1, 3'd3);
    chk("post.a_rej", a_rej, 16'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
